seg7x2_snoop_dec: RTL and testbench
===================================

// Module: seg7x2_snoop_dec
// PURPOSE
//  Decodes two active-low 7-segment digit buses (ones, tens; bit order {a,b,c,d,e,f,g}) back into a binary value 0..19.
//  Reverse path of the lab-6 two-digit display encoder; used in self-check benches and board loopback.
//  A decode is accepted only after the pattern has been stable for STABLE_CYCLES clocks.
//  Each distinct stable pattern produces one result, delivered over a valid/ready handshake.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before a pattern is accepted (>=1)
//  ERRCNT_W       8  width of the illegal-pattern counter (SEG7_DEC_ERRCNT_EN only)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  seg_ones   in   7         ones-digit segments {a..g}, active low
//  seg_tens   in   7         tens-digit segments {a..g}, active low
//  out_ready  in   1         consumer accepts the result this cycle
//  out_valid  out  1         result held and valid
//  out_value  out  5         decoded value 0..19; 5'd31 when out_err=1
//  out_err    out  1         illegal pattern on either digit
//  err_count  out  ERRCNT_W  saturating count of emitted error results (SEG7_DEC_ERRCNT_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at an edge): out_valid=0, out_value=0, out_err=0, err_count=0, stability counter=0, sample reg=7'h7F/7'h7F.
//    The "last emitted" record is cleared, so after reset the current stable pattern is emitted again. Reset mid-handshake drops the held result.
//  - Sampling: {seg_tens,seg_ones} registered every clock into samp.
//    If input != samp, cnt<=0; else cnt increments, saturating at STABLE_CYCLES-1.
//  - Ones legal patterns: 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5 0100000=6 0001111=7 0000000=8 0001100=9.
//  - Tens legal patterns: 1111111 (blank)=0, 1001111=1. Anything else on either digit is illegal.
//  - value = tens*10 + ones (5-bit, max 19). Illegal: out_value=5'd31, out_err=1.
//  - FSM, 2 states:
//    ST_TRACK: out_valid=0. When cnt==STABLE_CYCLES-1, input==samp, and samp differs from the last emitted pattern
//      (or none has been emitted): load out_value/out_err, record samp as last emitted, assert out_valid, go to ST_HOLD.
//    ST_HOLD: out_valid=1, outputs frozen. On out_ready=1, out_valid drops next edge and the FSM returns to ST_TRACK.
//  - Sampling and cnt keep running in ST_HOLD. A pattern that stabilises during HOLD is not lost: it emits on the
//    first TRACK cycle after the handshake, i.e. out_valid is low for exactly 1 cycle between results.
//    Intermediate patterns are dropped; only the latest stable pattern counts.
//  - Latency: a new pattern held constant from edge 0 asserts out_valid at edge STABLE_CYCLES+1.
//  - A glitch shorter than STABLE_CYCLES resets cnt and produces no result.
//    Returning to the last emitted pattern produces no result.
//  - STABLE_CYCLES=1: any pattern seen on 2 consecutive edges is accepted.
// CONFIGURATION
//  - SEG7_DEC_ERRCNT_EN defined: err_count port exists. Increments by 1 on each result emitted with out_err=1,
//    saturates at all-ones, and is cleared by rst.
//  - SEG7_DEC_ERRCNT_EN undefined: err_count port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - seg7_pkg (shared with the encoder):
//    - SEG_0..SEG_9 and SEG_BLANK 7-bit active-low constants
//    - VAL_W=5, VAL_ERR=5'd31
//    - state encoding ST_TRACK/ST_HOLD
//  - Sub-module seg7_digit_dec (combinational): pattern[6:0] -> {legal, blank, digit[3:0]}.
//    Two instances: ones needs legal & !blank; tens needs blank or digit==1.
//  - Top: sample register, stability counter, last-emitted register, FSM, optional error counter.
// TESTING
//  Run all tests with STABLE_CYCLES=4; run twice, with and without SEG7_DEC_ERRCNT_EN.
//  1 Decode 13: after reset, hold ones=0000110, tens=1001111 from edge 0 with out_ready=1 -> out_valid=1 at edge 5,
//    out_value=13, out_err=0, single-cycle pulse, no repeat.
//  2 Sweep 0..19: each value held 8 cycles, out_ready=1 -> 20 results in order, all out_err=0.
//    Tens blank with ones 0 -> value 0.
//  3 Glitch: stable 7 (0001111/1111111) emitted, then 3-cycle 8 (0000000), then back to 7 -> no further out_valid.
//  4 Backpressure: out_ready=0; 5 accepted, then inputs change to 9 and stay.
//    -> out_value stays 5 while held. Raise ready -> 5 accepted, valid low 1 cycle, then 9 presented.
//  5 Illegal: ones=1111110 -> out_valid with out_value=31, out_err=1; err_count=1 (macro on).
//    Repeat 300 distinct illegal/legal alternations -> err_count saturates at 255.
//  6 Reset mid-HOLD: rst high 1 cycle while holding 4 -> out_valid=0 next edge. Inputs still 4 -> 4 re-emitted at edge 5 after reset release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions (active-low, bit order {a,b,c,d,e,f,g}) used by the
// two-digit encoder and the snoop decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int               VAL_W   = 5;
  localparam logic [VAL_W-1:0] VAL_ERR = 5'd31;

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } digit_info_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational single-digit decoder: active-low segment pattern -> {legal, blank, digit}.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0]  pattern,
  output digit_info_t info
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    info = '{legal: 1'b1, blank: 1'b0, digit: 4'd0};
    unique case (pattern)
      SEG_0:     info.digit = 4'd0;
      SEG_1:     info.digit = 4'd1;
      SEG_2:     info.digit = 4'd2;
      SEG_3:     info.digit = 4'd3;
      SEG_4:     info.digit = 4'd4;
      SEG_5:     info.digit = 4'd5;
      SEG_6:     info.digit = 4'd6;
      SEG_7:     info.digit = 4'd7;
      SEG_8:     info.digit = 4'd8;
      SEG_9:     info.digit = 4'd9;
      SEG_BLANK: info.blank = 1'b1;
      default:   info.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7x2_snoop_dec.sv
// Two-digit active-low 7-segment snoop decoder: debounces {tens,ones} for STABLE_CYCLES
// and emits each new stable value once over valid/ready. Define SEG7_DEC_ERRCNT_EN for err_count.
module seg7x2_snoop_dec
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  parameter int ERRCNT_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_ones,
  input  logic [6:0]       seg_tens,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [VAL_W-1:0] out_value,
  output logic             out_err
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [13:0]      din;
  logic [13:0]      samp;
  logic [13:0]      last_pat;
  logic             last_vld;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_nxt;
  logic             stable_new;
  logic             accept;

  digit_info_t      ones_info;
  digit_info_t      tens_info;
  logic             ones_ok;
  logic             tens_ok;
  logic             dec_err;
  logic [VAL_W-1:0] tens_part;
  logic [VAL_W-1:0] dec_value;

  assign din = {seg_tens, seg_ones};

  // Sample register and stability counter run in every state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      samp <= {SEG_BLANK, SEG_BLANK};
      cnt  <= '0;
    end else begin
      samp <= din;
      if (din != samp)       cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  seg7_digit_dec u_ones_dec (.pattern(samp[6:0]),  .info(ones_info));
  seg7_digit_dec u_tens_dec (.pattern(samp[13:7]), .info(tens_info));

  // Ones must be a real digit; tens may only be blank (0) or a one.
  assign ones_ok   = ones_info.legal & ~ones_info.blank;
  assign tens_ok   = tens_info.blank | (tens_info.legal & (tens_info.digit == 4'd1));
  assign dec_err   = ~(ones_ok & tens_ok);
  assign tens_part = tens_info.blank ? '0 : VAL_W'(10);
  assign dec_value = dec_err ? VAL_ERR : tens_part + VAL_W'(ones_info.digit);

  assign stable_new = (cnt == CNT_MAX) && (din == samp) && (!last_vld || (samp != last_pat));
  assign accept     = (state == ST_TRACK) && stable_new;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_TRACK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_TRACK: if (stable_new) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready)  state_nxt = ST_TRACK;
      default:                  state_nxt = ST_TRACK;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_HOLD);
  end

  // Result and last-emitted record load together so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_value <= '0;
      out_err   <= 1'b0;
      last_pat  <= '0;
      last_vld  <= 1'b0;
    end else if (accept) begin
      out_value <= dec_value;
      out_err   <= dec_err;
      last_pat  <= samp;
      last_vld  <= 1'b1;
    end
  end

`ifdef SEG7_DEC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                        err_count <= '0;
    else if (accept && dec_err && (err_count != '1)) err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seg7x2_snoop_dec.sv
// Self-checking bench for seg7x2_snoop_dec: vector table, directed corner sequences and
// randomized traffic against a run-length reference model. Builds with or without SEG7_DEC_ERRCNT_EN.
module tb_seg7x2_snoop_dec;

  localparam int SC = 4;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_ONE   = 7'b1001111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_ones = 7'b1111111;
  logic [6:0] seg_tens = 7'b1111111;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [4:0] out_value;
  logic       out_err;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seg7x2_snoop_dec #(.STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_ones  (seg_ones),
    .seg_tens  (seg_tens),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_err   (out_err)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] ones_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

  int checks = 0;
  int errors = 0;
  int tick_no = 0;

  // Reference model state: length of the current run of identical samples.
  logic [13:0] m_run_pat;
  int          m_run_len;
  bit          m_hold;
  bit          m_last_vld;
  logic [13:0] m_last_pat;
  int          m_val;
  bit          m_err;
  int          m_errcnt;

  // Observation of results as they appear on the output.
  bit prev_valid = 1'b0;
  int n_res      = 0;
  int n_err_res  = 0;
  int res_value  = 0;
  int res_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s tick=%0d actual=%0d expected=%0d", name, tick_no, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [13:0] p);
    int o = -1;
    int t = -1;
    for (int i = 0; i < 10; i++) if (p[6:0] == ones_tab[i]) o = i;
    if (p[13:7] == P_BLANK)    t = 0;
    else if (p[13:7] == P_ONE) t = 1;
    if (o < 0 || t < 0) return 31;
    return t * 10 + o;
  endfunction

  task automatic model_step();
    logic [13:0] d;
    int v;
    d = {seg_tens, seg_ones};
    if (rst) begin
      m_run_pat  = 14'h3FFF;
      m_run_len  = 1;
      m_hold     = 1'b0;
      m_last_vld = 1'b0;
      m_last_pat = '0;
      m_val      = 0;
      m_err      = 1'b0;
      m_errcnt   = 0;
    end else begin
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (d == m_run_pat && m_run_len >= SC && (!m_last_vld || d != m_last_pat)) begin
        v          = ref_decode(d);
        m_hold     = 1'b1;
        m_val      = v;
        m_err      = (v == 31);
        m_last_vld = 1'b1;
        m_last_pat = d;
        if (m_err && m_errcnt < 255) m_errcnt++;
      end
      if (d == m_run_pat) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_pat = d;
        m_run_len = 1;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick_no++;
    check("valid", int'(out_valid), int'(m_hold));
    check("value", int'(out_value), m_val);
    check("err",   int'(out_err),   int'(m_err));
`ifdef SEG7_DEC_ERRCNT_EN
    check("err_count", int'(err_count), m_errcnt);
`endif
    if (out_valid && !prev_valid) begin
      n_res++;
      res_value = int'(out_value);
      res_err   = int'(out_err);
      if (out_err) n_err_res++;
    end
    prev_valid = out_valid;
  endtask

  task automatic drive(input logic [6:0] tens, input logic [6:0] ones);
    seg_tens = tens;
    seg_ones = ones;
  endtask

  typedef struct {
    logic [6:0] ones;
    logic [6:0] tens;
    int         exp_value;
    bit         exp_err;
  } vec_t;

  vec_t vecs [23];

  initial begin
    for (int i = 0; i < 20; i++)
      vecs[i] = '{ones: ones_tab[i % 10], tens: (i < 10) ? P_BLANK : P_ONE, exp_value: i, exp_err: 1'b0};
    vecs[20] = '{ones: 7'b1111110, tens: P_BLANK,     exp_value: 31, exp_err: 1'b1};
    vecs[21] = '{ones: 7'b0000001, tens: 7'b0000001,  exp_value: 31, exp_err: 1'b1};
    vecs[22] = '{ones: P_BLANK,    tens: P_ONE,       exp_value: 31, exp_err: 1'b1};

    // Reset state
    rst = 1'b1;
    drive(P_BLANK, P_BLANK);
    tick();
    tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_value", int'(out_value), 0);
    check("rst_err",   int'(out_err),   0);
`ifdef SEG7_DEC_ERRCNT_EN
    check("rst_err_count", int'(err_count), 0);
`endif

    // Decode 13 with exact latency and a single pulse
    out_ready = 1'b1;
    drive(P_ONE, 7'b0000110);
    tick();
    rst = 1'b0;
    n_res = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1_early_valid", int'(out_valid), 0);
    end
    tick();
    check("t1_valid_edge5", int'(out_valid), 1);
    check("t1_value", int'(out_value), 13);
    check("t1_err", int'(out_err), 0);
    tick();
    check("t1_pulse_end", int'(out_valid), 0);
    repeat (10) tick();
    check("t1_no_repeat", n_res, 1);

    // Vector table: each row held 8 cycles must give exactly one matching result
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].tens, vecs[i].ones);
      n_res = 0;
      repeat (8) tick();
      check("vec_count", n_res, 1);
      check("vec_value", res_value, vecs[i].exp_value);
      check("vec_err",   res_err,   int'(vecs[i].exp_err));
    end

    // Glitch: a short excursion and a return to the last emitted value are silent
    drive(P_BLANK, ones_tab[7]);
    n_res = 0;
    repeat (8) tick();
    check("glitch_first", res_value, 7);
    n_res = 0;
    drive(P_BLANK, ones_tab[8]);
    repeat (3) tick();
    drive(P_BLANK, ones_tab[7]);
    repeat (12) tick();
    check("glitch_silent", n_res, 0);

    // Backpressure: held result frozen while a newer pattern stabilises behind it
    out_ready = 1'b0;
    drive(P_BLANK, ones_tab[5]);
    repeat (8) tick();
    check("bp_valid5", int'(out_valid), 1);
    drive(P_BLANK, ones_tab[9]);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_value", int'(out_value), 5);
    end
    out_ready = 1'b1;
    tick();
    check("bp_gap", int'(out_valid), 0);
    tick();
    check("bp_next_valid", int'(out_valid), 1);
    check("bp_next_value", int'(out_value), 9);
    tick();

    // Reset while holding a result
    out_ready = 1'b0;
    drive(P_BLANK, ones_tab[4]);
    repeat (8) tick();
    check("rh_holding", int'(out_value), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rh_dropped", int'(out_valid), 0);
    check("rh_value_cleared", int'(out_value), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rh_wait", int'(out_valid), 0);
    end
    tick();
    check("rh_reemit_valid", int'(out_valid), 1);
    check("rh_reemit_value", int'(out_value), 4);
    out_ready = 1'b1;
    tick();

    // Illegal patterns and error counter saturation
    rst = 1'b1;
    drive(P_BLANK, 7'b1111110);
    tick();
    rst = 1'b0;
    n_err_res = 0;
    repeat (6) tick();
    check("ill_value", res_value, 31);
    check("ill_err", res_err, 1);
`ifdef SEG7_DEC_ERRCNT_EN
    check("ill_err_count1", int'(err_count), 1);
`endif
    for (int k = 0; k < 300; k++) begin
      drive(P_BLANK, ones_tab[0]);
      repeat (6) tick();
      drive(P_BLANK, 7'b1111110);
      repeat (6) tick();
    end
    check("ill_err_results", n_err_res, 301);
`ifdef SEG7_DEC_ERRCNT_EN
    check("ill_err_count_sat", int'(err_count), 255);
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      int sel;
      int len;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        int v;
        v = int'($urandom_range(0, 19));
        drive((v < 10) ? P_BLANK : P_ONE, ones_tab[v % 10]);
      end else if (sel < 8) begin
        drive(P_BLANK, 7'($urandom));
      end else begin
        drive(7'($urandom), ones_tab[$urandom_range(0, 9)]);
      end
      len = int'($urandom_range(1, SC + 4));
      for (int j = 0; j < len; j++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        rst       = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst = 1'b0;
    end
    out_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
